// File: rtl/mmcm_ps_responder.sv
// Responder model of the MMCM dynamic phase-shift port (psen/psincdec/psdone).
// Define MMCM_PS_STATS_EN to enable the inc_count/dec_count statistics.
module mmcm_ps_responder #(
    parameter int unsigned PSDONE_LATENCY  = 12,
    parameter int unsigned STEPS_PER_CYCLE = 448,
    parameter int unsigned PHASE_WIDTH     = 16
) (
    input  logic                   psclk,
    input  logic                   reset,
    input  logic                   psen,
    input  logic                   psincdec,
    input  logic                   err_clr,
    output logic                   psdone,
    output logic                   busy,
    output logic [PHASE_WIDTH-1:0] phase_steps,
    output logic                   phase_wrap,
    output logic                   wrap_dir,
    output logic [31:0]            total_offset,
    output logic                   ps_err,
    output logic [15:0]            inc_count,
    output logic [15:0]            dec_count
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [7:0] LAT_LOAD = 8'(PSDONE_LATENCY - 1);
    localparam logic [PHASE_WIDTH-1:0] PH_MAX =
        PHASE_WIDTH'(STEPS_PER_CYCLE - 1);
    localparam logic [31:0] OFS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] OFS_MIN = 32'h8000_0000;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic                   psdone_q, psdone_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   wrap_q, wrap_d;
    logic                   wdir_q, wdir_d;
    logic [31:0]            ofs_q, ofs_d;
    logic                   err_q, err_d;
    logic                   step;
    logic                   viol;

    always_ff @(posedge psclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            psdone_q <= 1'b0;
            phase_q  <= '0;
            wrap_q   <= 1'b0;
            wdir_q   <= 1'b0;
            ofs_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            psdone_q <= psdone_d;
            phase_q  <= phase_d;
            wrap_q   <= wrap_d;
            wdir_q   <= wdir_d;
            ofs_q    <= ofs_d;
            err_q    <= err_d;
        end
    end

    // The step completes on the edge that enters the counter==0 cycle,
    // so psdone and the phase update become visible together.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        psdone_d = 1'b0;
        phase_d  = phase_q;
        wrap_d   = 1'b0;
        wdir_d   = wdir_q;
        ofs_d    = ofs_q;
        step     = 1'b0;
        viol     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (psen) begin
                    state_d = BUSY;
                    cnt_d   = LAT_LOAD;
                    dir_d   = psincdec;
                end
            end
            BUSY: begin
                viol = psen;
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    step  = (cnt_q == 8'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (step) begin
            psdone_d = 1'b1;
            if (dir_q) begin
                if (phase_q == PH_MAX) begin
                    phase_d = '0;
                    wrap_d  = 1'b1;
                    wdir_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
                if (ofs_q != OFS_MAX) begin
                    ofs_d = ofs_q + 32'd1;
                end
            end else begin
                if (phase_q == '0) begin
                    phase_d = PH_MAX;
                    wrap_d  = 1'b1;
                    wdir_d  = 1'b0;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
                if (ofs_q != OFS_MIN) begin
                    ofs_d = ofs_q - 32'd1;
                end
            end
        end

        // A violation outranks a coincident clear.
        if (viol) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign psdone       = psdone_q;
    assign busy         = (state_q == BUSY);
    assign phase_steps  = phase_q;
    assign phase_wrap   = wrap_q;
    assign wrap_dir     = wdir_q;
    assign total_offset = ofs_q;
    assign ps_err       = err_q;

`ifdef MMCM_PS_STATS_EN
    logic [15:0] inc_cnt_q, inc_cnt_d;
    logic [15:0] dec_cnt_q, dec_cnt_d;
    logic [15:0] inc_base;
    logic [15:0] dec_base;

    always_ff @(posedge psclk or posedge reset) begin
        if (reset) begin
            inc_cnt_q <= '0;
            dec_cnt_q <= '0;
        end else begin
            inc_cnt_q <= inc_cnt_d;
            dec_cnt_q <= dec_cnt_d;
        end
    end

    // A step completing alongside a clear is counted after the clear.
    always_comb begin
        inc_base  = err_clr ? 16'd0 : inc_cnt_q;
        dec_base  = err_clr ? 16'd0 : dec_cnt_q;
        inc_cnt_d = inc_base;
        dec_cnt_d = dec_base;
        if (step && dir_q && (inc_base != 16'hFFFF)) begin
            inc_cnt_d = inc_base + 16'd1;
        end
        if (step && !dir_q && (dec_base != 16'hFFFF)) begin
            dec_cnt_d = dec_base + 16'd1;
        end
    end

    assign inc_count = inc_cnt_q;
    assign dec_count = dec_cnt_q;
`else
    assign inc_count = 16'd0;
    assign dec_count = 16'd0;
`endif

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Directed self-checking bench for mmcm_ps_responder.
// Expected values are hand-derived from the phase-shift port timing.
module tb_mmcm_ps_responder;

`ifdef MMCM_PS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        psclk;
    logic        reset;
    logic        psen;
    logic        psincdec;
    logic        err_clr;
    logic        psdone;
    logic        busy;
    logic [15:0] phase_steps;
    logic        phase_wrap;
    logic        wrap_dir;
    logic [31:0] total_offset;
    logic        ps_err;
    logic [15:0] inc_count;
    logic [15:0] dec_count;

    int checks = 0;
    int errors = 0;

    mmcm_ps_responder #(
        .PSDONE_LATENCY (12),
        .STEPS_PER_CYCLE(448),
        .PHASE_WIDTH    (16)
    ) dut (
        .psclk       (psclk),
        .reset       (reset),
        .psen        (psen),
        .psincdec    (psincdec),
        .err_clr     (err_clr),
        .psdone      (psdone),
        .busy        (busy),
        .phase_steps (phase_steps),
        .phase_wrap  (phase_wrap),
        .wrap_dir    (wrap_dir),
        .total_offset(total_offset),
        .ps_err      (ps_err),
        .inc_count   (inc_count),
        .dec_count   (dec_count)
    );

    initial begin
        psclk = 1'b0;
        forever #5 psclk = ~psclk;
    end

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge psclk);
        #1;
    endtask

    // Leaves the bench at the start of "cycle 0" with reset released.
    task automatic do_reset();
        reset    = 1'b1;
        psen     = 1'b0;
        psincdec = 1'b0;
        err_clr  = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        psen     = 1'b0;
        psincdec = 1'b0;
        err_clr  = 1'b0;
        #1;
        repeat (2) cyc();
        checks++;
        if ({psdone, busy, phase_wrap, wrap_dir, ps_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000",
                     {psdone, busy, phase_wrap, wrap_dir, ps_err});
        end
        checks++;
        if (phase_steps !== 16'd0 || total_offset !== 32'd0) begin
            errors++;
            $display("FAIL reset_phase got=%0d/%h want=0/0",
                     phase_steps, total_offset);
        end
        checks++;
        if (inc_count !== 16'd0 || dec_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts got=%0d/%0d want=0/0",
                     inc_count, dec_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_inc();
        do_reset();
        psen     = 1'b1;
        psincdec = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            psen = 1'b0;
            checks++;
            if (busy !== (k <= 12)) begin
                errors++;
                $display("FAIL inc_busy c%0d got=%b want=%b",
                         k, busy, (k <= 12));
            end
            checks++;
            if (psdone !== (k == 12)) begin
                errors++;
                $display("FAIL inc_psdone c%0d got=%b want=%b",
                         k, psdone, (k == 12));
            end
            checks++;
            if (phase_steps !== ((k >= 12) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL inc_phase c%0d got=%0d", k, phase_steps);
            end
            if (k == 12) begin
                checks++;
                if (total_offset !== 32'd1) begin
                    errors++;
                    $display("FAIL inc_offset got=%h want=1", total_offset);
                end
                checks++;
                if (inc_count !== (STATS ? 16'd1 : 16'd0)) begin
                    errors++;
                    $display("FAIL inc_count got=%0d want=%0d",
                             inc_count, STATS ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_dec_wrap();
        do_reset();
        psen     = 1'b1;
        psincdec = 1'b0;
        cyc();
        psen     = 1'b0;
        psincdec = 1'b1;
        repeat (11) cyc();
        checks++;
        if (psdone !== 1'b1 || phase_wrap !== 1'b1 || wrap_dir !== 1'b0) begin
            errors++;
            $display("FAIL dec_wrap_flags got=%b%b%b want=110",
                     psdone, phase_wrap, wrap_dir);
        end
        checks++;
        if (phase_steps !== 16'd447) begin
            errors++;
            $display("FAIL dec_wrap_phase got=%0d want=447", phase_steps);
        end
        checks++;
        if (total_offset !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL dec_wrap_offset got=%h want=ffffffff",
                     total_offset);
        end
        checks++;
        if (dec_count !== (STATS ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL dec_count got=%0d", dec_count);
        end
        cyc();
        checks++;
        if (phase_wrap !== 1'b0 || wrap_dir !== 1'b0
            || phase_steps !== 16'd447) begin
            errors++;
            $display("FAIL dec_wrap_after got=%b%b/%0d want=00/447",
                     phase_wrap, wrap_dir, phase_steps);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        psincdec = 1'b1;
        for (int i = 0; i < 448; i++) begin
            psen = 1'b1;
            cyc();
            psen = 1'b0;
            repeat (11) cyc();
            checks++;
            if (psdone !== 1'b1
                || phase_steps !== 16'((i + 1) % 448)) begin
                errors++;
                bad++;
                if (bad < 5) begin
                    $display("FAIL b2b_step%0d got=%b/%0d want=1/%0d",
                             i, psdone, phase_steps, (i + 1) % 448);
                end
            end
            if (i < 447) begin
                cyc();
            end
        end
        checks++;
        if (phase_wrap !== 1'b1 || wrap_dir !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap_flags got=%b%b want=11",
                     phase_wrap, wrap_dir);
        end
        checks++;
        if (total_offset !== 32'd448 || ps_err !== 1'b0) begin
            errors++;
            $display("FAIL inc_wrap_ofs got=%0d err=%b want=448 err=0",
                     total_offset, ps_err);
        end
        checks++;
        if (inc_count !== (STATS ? 16'd448 : 16'd0)) begin
            errors++;
            $display("FAIL inc_wrap_count got=%0d", inc_count);
        end
        cyc();
    endtask

    task automatic test_violation();
        do_reset();
        psen     = 1'b1;
        psincdec = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            cyc();
            psen     = (k == 5) || (k == 12);
            psincdec = (k == 5) ? 1'b0 : 1'b1;
            err_clr  = (k == 20);
            checks++;
            if (psdone !== (k == 12)) begin
                errors++;
                $display("FAIL viol_psdone c%0d got=%b", k, psdone);
            end
            checks++;
            if (ps_err !== (k >= 6 && k <= 20)) begin
                errors++;
                $display("FAIL viol_err c%0d got=%b want=%b",
                         k, ps_err, (k >= 6 && k <= 20));
            end
            checks++;
            if (busy !== (k <= 12)) begin
                errors++;
                $display("FAIL viol_busy c%0d got=%b", k, busy);
            end
        end
        err_clr = 1'b0;
        checks++;
        if (phase_steps !== 16'd1 || total_offset !== 32'd1) begin
            errors++;
            $display("FAIL viol_phase got=%0d/%0d want=1/1",
                     phase_steps, total_offset);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        psen     = 1'b1;
        psincdec = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            psen  = 1'b0;
            reset = (k == 6) || (k == 7);
            #1;
            if (k == 6) begin
                checks++;
                if ({busy, psdone, ps_err} !== 3'b0
                    || phase_steps !== 16'd0) begin
                    errors++;
                    $display("FAIL rst_mid_now got=%b%b%b/%0d",
                             busy, psdone, ps_err, phase_steps);
                end
            end
            checks++;
            if (psdone !== 1'b0 || phase_steps !== 16'd0) begin
                errors++;
                $display("FAIL rst_mid_c%0d got=%b/%0d want=0/0",
                         k, psdone, phase_steps);
            end
        end
        psen = 1'b1;
        cyc();
        psen = 1'b0;
        repeat (11) cyc();
        checks++;
        if (psdone !== 1'b1 || phase_steps !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_restep got=%b/%0d want=1/1",
                     psdone, phase_steps);
        end
    endtask

    task automatic test_clr_vs_viol();
        do_reset();
        psen     = 1'b1;
        psincdec = 1'b0;
        repeat (3) cyc();
        psen    = 1'b1;
        err_clr = 1'b1;
        cyc();
        psen = 1'b0;
        checks++;
        if (ps_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_viol got=%b want=1", ps_err);
        end
        cyc();
        err_clr = 1'b0;
        checks++;
        if (ps_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone got=%b want=0", ps_err);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_busy got=%b want=1", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_dec_wrap();
        test_back_to_back();
        test_violation();
        test_reset_mid();
        test_clr_vs_viol();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
